int_ctrl: RTL and testbench

Four-source interrupt controller that sits beside the multi-cycle CPU and drives its `Ireq`/`gntInt[3:0]` inputs. It captures rising edges from peripheral interrupt lines into a pending register, selects the highest-priority enabled source, and holds a stable request/grant until the CPU control unit returns `Iack`. The CPU's interrupt-enable output gates the request. Software can read and modify the controller's enable, pending and end-of-interrupt registers over a small single-cycle-ack slave port on the same bus as other MIO peripherals.

---
 rtl/int_ctrl.sv | 173 +++++++++++++++++
 tb/tb_int_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: four-source interrupt controller for the multi-cycle CPU.
// Captures rising edges of peripheral interrupt lines into PEND, picks the
// highest-priority enabled source (bit 0 highest), and holds Ireq/gntInt
// steady until the CPU acknowledges with Iack. Software sees PEND, IEN, EOI
// and STAT through a single-cycle-ack slave port.
//
// Ports:
//   clk, reset        system clock (rising edge), async active-low reset
//   irq_src[3:0]      raw peripheral interrupt lines (asynchronous)
//   int_en            CPU global interrupt enable
//   Iack              CPU interrupt acknowledge pulse
//   Ireq, gntInt      request and one-hot grant to the CPU
//   stb_i, we_i,
//   addr_i, dat_i     slave access: 0=PEND 1=IEN 2=EOI 3=STAT
//   dat_o, ack_o      read data and access acknowledge
//   in_service        one-hot source being serviced (status)
module int_ctrl #(
  parameter int unsigned N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             int_en,
  input  logic             Iack,
  output logic             Ireq,
  output logic [N_SRC-1:0] gntInt,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic [N_SRC-1:0] in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ireq;
  logic [N_SRC-1:0] r_gnt;
  logic [N_SRC-1:0] r_insvc;
  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_ien;
  logic             r_ack;
  logic [31:0]      r_dat;

  logic             w_access;
  logic             w_wr;
  logic             w_eoi;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_pend_clr;
  logic [N_SRC-1:0] w_iack_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_pick;
  logic [31:0]      w_rdata;
  logic             w_unused_dat;

  // An access is taken only when no ack is outstanding, so a held strobe
  // is acknowledged every other cycle.
  assign w_access   = stb_i & ~r_ack;
  assign w_wr       = w_access & we_i;
  assign w_eoi      = w_wr && (addr_i == 2'd2);
  assign w_pend_clr = (w_wr && (addr_i == 2'd0)) ? dat_i[N_SRC-1:0] : '0;
  assign w_iack_clr = ((r_state == REQ) && Iack) ? r_gnt : '0;
  assign w_rise     = r_sync2 & ~r_prev;
  // A newly detected edge beats any clear arriving in the same cycle.
  assign w_pend_nxt = (r_pend & ~(w_pend_clr | w_iack_clr)) | w_rise;
  assign w_elig     = r_pend & r_ien;
  assign w_unused_dat = ^dat_i[31:N_SRC];

  always_comb begin
    w_pick = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (w_elig[i] && (w_pick == '0)) begin
        w_pick[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      2'd0:    w_rdata = {{(32-N_SRC){1'b0}}, r_pend};
      2'd1:    w_rdata = {{(32-N_SRC){1'b0}}, r_ien};
      2'd3:    w_rdata = {{(32-2-N_SRC){1'b0}}, r_state, r_insvc};
      default: w_rdata = '0;
    endcase
  end

  // Input synchronizers, edge detect and software-visible registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_ien   <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pend  <= w_pend_nxt;
      if (w_wr && (addr_i == 2'd1)) begin
        r_ien <= dat_i[N_SRC-1:0];
      end
      r_ack <= w_access;
      r_dat <= (w_access && !we_i) ? w_rdata : '0;
    end
  end

  // Request/grant FSM. Withdrawal is judged on registered PEND/IEN, so a
  // software clear or disable of the granted source drops Ireq one cycle
  // after the register changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ireq  <= 1'b0;
      r_gnt   <= '0;
      r_insvc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (int_en && (w_elig != '0)) begin
            r_state <= REQ;
            r_gnt   <= w_pick;
            r_ireq  <= 1'b1;
          end
        end
        REQ: begin
          if (Iack) begin
            r_state <= SERVICE;
            r_insvc <= r_gnt;
            r_gnt   <= '0;
            r_ireq  <= 1'b0;
          end else if (!int_en || ((r_gnt & r_pend & r_ien) == '0)) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ireq  <= 1'b0;
          end
        end
        SERVICE: begin
          if (w_eoi) begin
            r_state <= IDLE;
            r_insvc <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_ireq  <= 1'b0;
          r_insvc <= '0;
        end
      endcase
    end
  end

  assign Ireq       = r_ireq;
  assign gntInt     = r_gnt;
  assign in_service = r_insvc;
  assign ack_o      = r_ack;
  assign dat_o      = r_dat;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic        int_en;
  logic        Iack;
  logic        Ireq;
  logic [3:0]  gntInt;
  logic        stb_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [3:0]  in_service;

  int unsigned total;
  int unsigned bad;
  logic [31:0] sb_q[$];

  int_ctrl #(.N_SRC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .int_en     (int_en),
    .Iack       (Iack),
    .Ireq       (Ireq),
    .gntInt     (gntInt),
    .stb_i      (stb_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .ack_o      (ack_o),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    stb_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = a;
    dat_i  = d;
    tick();
    chk("wr_ack", {31'b0, ack_o}, 32'd1);
    stb_i = 1'b0;
    we_i  = 1'b0;
    dat_i = '0;
    tick();
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    int n;
    logic [31:0] e;
    sb_q.push_back(exp);
    stb_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = a;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_o && n < 8);
    chk("rd_ack_lat", n, 32'd1);
    e = sb_q.pop_front();
    chk(tag, dat_o, e);
    stb_i = 1'b0;
    tick();
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq_src = v;
    tick();
    irq_src = '0;
  endtask

  task automatic do_iack();
    Iack = 1'b1;
    tick();
    Iack = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    irq_src = '0;
    int_en  = 1'b0;
    Iack    = 1'b0;
    stb_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    dat_i   = '0;
    ticks(2);
    chk("rst_ireq", {31'b0, Ireq}, 32'd0);
    chk("rst_gnt", {28'b0, gntInt}, 32'd0);
    chk("rst_insvc", {28'b0, in_service}, 32'd0);
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    reset = 1'b1;
    tick();

    // Single source with edge-to-request latency.
    bus_write(2'd1, 32'h4);
    int_en = 1'b1;
    pulse_irq(4'b0100);
    ticks(2);
    chk("lat_ireq_e2", {31'b0, Ireq}, 32'd0);
    tick();
    chk("lat_ireq_e3", {31'b0, Ireq}, 32'd1);
    chk("single_gnt", {28'b0, gntInt}, 32'h4);
    do_iack();
    chk("iack_ireq", {31'b0, Ireq}, 32'd0);
    chk("iack_gnt", {28'b0, gntInt}, 32'd0);
    chk("iack_insvc", {28'b0, in_service}, 32'h4);
    bus_read("stat_svc", 2'd3, 32'h24);
    bus_read("pend_after_iack", 2'd0, 32'h0);
    bus_write(2'd2, 32'hDEAD_BEEF);
    bus_read("stat_eoi", 2'd3, 32'h0);
    bus_read("eoi_reads0", 2'd2, 32'h0);

    // Priority between simultaneous sources.
    bus_write(2'd1, 32'hF);
    pulse_irq(4'b1010);
    ticks(3);
    chk("prio_gnt", {28'b0, gntInt}, 32'h2);
    do_iack();
    bus_write(2'd2, 32'h0);
    chk("prio_next_gnt", {28'b0, gntInt}, 32'h8);
    chk("prio_next_ireq", {31'b0, Ireq}, 32'd1);

    // No preemption by a higher-priority late arrival.
    pulse_irq(4'b0001);
    ticks(4);
    chk("nopre_gnt", {28'b0, gntInt}, 32'h8);
    bus_read("nopre_pend", 2'd0, 32'h9);
    do_iack();
    bus_read("nopre_pend_after", 2'd0, 32'h1);
    bus_write(2'd2, 32'h0);
    chk("nopre_src0_gnt", {28'b0, gntInt}, 32'h1);
    do_iack();
    bus_write(2'd2, 32'h0);
    ticks(2);
    chk("idle_ireq", {31'b0, Ireq}, 32'd0);

    // Withdraw on int_en drop, reassert, then withdraw by PEND clear.
    pulse_irq(4'b0010);
    ticks(3);
    chk("wd_gnt", {28'b0, gntInt}, 32'h2);
    int_en = 1'b0;
    tick();
    chk("wd_ireq", {31'b0, Ireq}, 32'd0);
    chk("wd_gnt0", {28'b0, gntInt}, 32'd0);
    bus_read("wd_stat", 2'd3, 32'h0);
    bus_read("wd_pend", 2'd0, 32'h2);
    int_en = 1'b1;
    tick();
    chk("reassert_ireq", {31'b0, Ireq}, 32'd1);
    chk("reassert_gnt", {28'b0, gntInt}, 32'h2);
    bus_write(2'd0, 32'h2);
    chk("w1c_wd_ireq", {31'b0, Ireq}, 32'd0);
    bus_read("w1c_pend", 2'd0, 32'h0);

    // Set/clear collision: software clear lands on the edge-detect cycle.
    bus_write(2'd1, 32'h0);
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    tick();
    bus_write(2'd0, 32'h1);
    bus_read("collide_pend", 2'd0, 32'h1);
    bus_write(2'd0, 32'h1);
    bus_read("collide_clr", 2'd0, 32'h0);

    // Two edges on an already-pending source merge into one interrupt.
    pulse_irq(4'b1000);
    ticks(4);
    pulse_irq(4'b1000);
    ticks(4);
    bus_read("merge_pend", 2'd0, 32'h8);
    bus_write(2'd1, 32'h8);
    chk("merge_ireq", {31'b0, Ireq}, 32'd1);
    do_iack();
    bus_write(2'd2, 32'h0);
    ticks(3);
    chk("merge_once", {31'b0, Ireq}, 32'd0);

    // Bus width masking and back-to-back strobe acking.
    bus_write(2'd1, 32'hFFFF_FFF5);
    bus_read("ien_mask", 2'd1, 32'h5);
    stb_i  = 1'b1;
    addr_i = 2'd1;
    tick();
    chk("b2b_ack1", {31'b0, ack_o}, 32'd1);
    tick();
    chk("b2b_ack2", {31'b0, ack_o}, 32'd0);
    tick();
    chk("b2b_ack3", {31'b0, ack_o}, 32'd1);
    stb_i = 1'b0;
    tick();

    // Asynchronous reset while requesting and acking.
    pulse_irq(4'b0001);
    ticks(3);
    chk("pre_rst_ireq", {31'b0, Ireq}, 32'd1);
    stb_i  = 1'b1;
    addr_i = 2'd1;
    tick();
    stb_i = 1'b0;
    chk("pre_rst_dat", dat_o, 32'h5);
    #2 reset = 1'b0;
    #1;
    chk("arst_ireq", {31'b0, Ireq}, 32'd0);
    chk("arst_gnt", {28'b0, gntInt}, 32'd0);
    chk("arst_ack", {31'b0, ack_o}, 32'd0);
    chk("arst_dat", dat_o, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ticks(2);
    bus_read("arst_pend", 2'd0, 32'h0);
    bus_read("arst_ien", 2'd1, 32'h0);
    chk("arst_ireq_after", {31'b0, Ireq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
